ysyx_25030085_wb_sched: RTL and testbench
=========================================

// Module: ysyx_25030085_wb_sched
// PURPOSE
//  Write-back scheduler for the single write port of the 32x32 integer register file.
//  Arbitrates between the EXU result path (ALU / PC+4 / LUI imm) and the LSU load-response path.
//  Keeps a per-register pending-load scoreboard and raises decode stalls on RAW/WAW hazards.
//  Enables multi-cycle loads with up to MAX_OUTSTANDING loads in flight.
// PARAMETERS
//  MAX_OUTSTANDING  4  max load issues accepted but not yet written back (>=1)
//  STARVE_LIMIT     3  consecutive lost arbitrations after which EXU wins once (>=1)
//  CNT_W            $clog2(MAX_OUTSTANDING+1)  width of the outstanding counter (derived, localparam)
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst             in   1   synchronous reset, active-high
//  exu_valid       in   1   EXU write-back request
//  exu_ready       out  1   EXU request accepted this cycle
//  exu_rd          in   5   EXU destination register
//  exu_data        in   32  EXU write data
//  ld_issue_valid  in   1   LSU issuing a load
//  ld_issue_ready  out  1   load issue accepted
//  ld_issue_rd     in   5   load destination register
//  ld_resp_valid   in   1   load data returned
//  ld_resp_ready   out  1   load response accepted
//  ld_resp_rd      in   5   load response destination
//  ld_resp_data    in   32  load data
//  dec_rs1/rs2/rd  in   5   operands of the instruction in decode
//  dec_stall       out  1   decode must hold
//  rf_wen          out  1   register-file write enable
//  rf_waddr        out  5   register-file write address
//  rf_wdata        out  32  register-file write data
//  outstanding     out  CNT_W  loads in flight
//  proto_err       out  1   sticky: response for a non-pending rd, or response with count 0
// BEHAVIOUR
//  - Handshake: a transfer happens when valid&ready are high at posedge. ready never depends on the same port's data.
//  - Reset: pending=0, outstanding=0, starve_cnt=0, proto_err=0.
//  - While rst=1, every ready output and rf_wen are 0. Responses arriving during reset are dropped.
//  - Scoreboard pending[31:0] is registered. Bit 0 is always 0.
//    - Set on a load-issue handshake when ld_issue_rd!=0.
//    - Cleared on a load-response handshake.
//    - Set and clear of the same rd in one cycle: set wins.
//  - dec_stall = rd!=0 and pending[rd] for any of rs1/rs2/rd. Uses registered pending only; no same-cycle clear bypass.
//  - Arbitration, one write per cycle:
//    - ld_resp wins by default.
//    - EXU wins when starve_cnt==STARVE_LIMIT.
//    - exu_ready = exu_valid & ~pending[exu_rd] & (EXU wins or ~ld_resp_valid).
//    - ld_resp_ready = ~rst & ~(EXU wins & exu_valid & ~pending[exu_rd]).
//  - starve_cnt:
//    - Increments (saturating) when exu_valid is high and exu_ready is low because of arbitration only.
//    - Clears on an EXU handshake or when exu_valid is low.
//    - Holds on a pending-hazard block.
//  - Write port (combinational, 0-cycle; the RF captures at the same posedge):
//    - rf_wen = granted handshake & rd!=0.
//    - rf_waddr / rf_wdata come from the winner. Writes to x0 are suppressed but the handshake still completes.
//  - ld_issue_ready = ~rst & (outstanding < MAX_OUTSTANDING).
//    - No credit from a same-cycle response.
//  - outstanding: +1 on issue, -1 on response, unchanged on both.
//    - A response when outstanding==0 sets proto_err and leaves the counter at 0.
//  - A response to an rd!=0 whose pending bit is clear sets proto_err; the data is still written.
//  - Reset mid-operation clears all state. The LSU is reset by the same rst.
// STRUCTURE
//  - Package ysyx_25030085_pkg: XLEN=32, REG_AW=5, NUM_REGS=32, and typedef reg_addr_t.
//  - Sub-module ysyx_25030085_scoreboard holds the pending vector:
//    - set/clear ports;
//    - 3 read ports for decode, 1 read port for exu_rd, 1 read port for resp check.
//  - The top level holds the arbiter, starve counter, outstanding counter and proto_err.
// TESTING
//  1 ALU only: exu_valid, rd=5, data=0x1234 -> same cycle exu_ready=1, rf_wen=1, waddr=5, wdata=0x1234.
//  2 Load RAW: issue rd=7; next cycle dec_rs1=7 -> dec_stall=1.
//    Resp rd=7, data=0xCAFE -> rf write x7. Next cycle dec_stall=0.
//  3 Conflict: ld_resp and exu both valid for 4 cycles, STARVE_LIMIT=3 -> grants LD,LD,LD,EXU.
//    starve_cnt=0 after the EXU grant.
//  4 Full: 4 issues with no responses -> outstanding=4, ld_issue_ready=0.
//    One response -> outstanding=3, ready=1 next cycle.
//  5 Edge cases:
//    - issue rd=0 -> no pending bit; its response -> rf_wen=0, outstanding decrements.
//    - exu_rd=9 while pending[9] -> exu_ready=0.
//    - response for non-pending rd=3 -> proto_err=1.
//  6 Reset with 2 loads in flight -> outstanding=0, pending=0, proto_err=0, dec_stall=0.

Source files
------------

// File: rtl/ysyx_25030085_pkg.sv
// ============================================================================
// Module   : ysyx_25030085_pkg
// Brief    : Shared integer-core widths and register-address helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_25030085_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25030085_scoreboard.sv
// ============================================================================
// Module   : ysyx_25030085_scoreboard
// Brief    : Per-register pending-load bits with decode, EXU and response reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25030085_scoreboard
    import ysyx_25030085_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      set_en,
    input  reg_addr_t set_rd,
    input  logic      clr_en,
    input  reg_addr_t clr_rd,
    input  reg_addr_t dec_rs1,
    input  reg_addr_t dec_rs2,
    input  reg_addr_t dec_rd,
    input  reg_addr_t exu_rd,
    input  reg_addr_t resp_rd,
    output logic      pend_rs1,
    output logic      pend_rs2,
    output logic      pend_rd,
    output logic      pend_exu,
    output logic      pend_resp
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_pending_next;

    always_comb begin
        w_set_mask = (set_en && set_rd != '0) ? reg_onehot(set_rd) : '0;
        w_clr_mask = clr_en ? reg_onehot(clr_rd) : '0;
        // OR-ing the set after the clear lets a same-cycle reissue keep the bit
        w_pending_next = ((r_pending & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign pend_rs1  = r_pending[dec_rs1];
    assign pend_rs2  = r_pending[dec_rs2];
    assign pend_rd   = r_pending[dec_rd];
    assign pend_exu  = r_pending[exu_rd];
    assign pend_resp = r_pending[resp_rd];

endmodule

`default_nettype wire

// File: rtl/ysyx_25030085_wb_sched.sv
// ============================================================================
// Module   : ysyx_25030085_wb_sched
// Brief    : Register-file write-back arbiter for EXU results and load data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25030085_wb_sched
    import ysyx_25030085_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int STARVE_LIMIT    = 3,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exu_valid,
    output logic             exu_ready,
    input  reg_addr_t        exu_rd,
    input  logic [XLEN-1:0]  exu_data,
    input  logic             ld_issue_valid,
    output logic             ld_issue_ready,
    input  reg_addr_t        ld_issue_rd,
    input  logic             ld_resp_valid,
    output logic             ld_resp_ready,
    input  reg_addr_t        ld_resp_rd,
    input  logic [XLEN-1:0]  ld_resp_data,
    input  reg_addr_t        dec_rs1,
    input  reg_addr_t        dec_rs2,
    input  reg_addr_t        dec_rd,
    output logic             dec_stall,
    output logic             rf_wen,
    output reg_addr_t        rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [CNT_W-1:0] outstanding,
    output logic             proto_err
);

    localparam int                SW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] w_outstanding_next;
    logic [SW-1:0]    r_starve_cnt;
    logic             r_proto_err;

    logic w_pend_rs1, w_pend_rs2, w_pend_rd, w_pend_exu, w_pend_resp;
    logic w_exu_wins, w_exu_eligible, w_exu_hs, w_resp_hs, w_issue_hs;
    logic w_arb_loss, w_resp_bad;

    ysyx_25030085_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (w_issue_hs),
        .set_rd    (ld_issue_rd),
        .clr_en    (w_resp_hs),
        .clr_rd    (ld_resp_rd),
        .dec_rs1   (dec_rs1),
        .dec_rs2   (dec_rs2),
        .dec_rd    (dec_rd),
        .exu_rd    (exu_rd),
        .resp_rd   (ld_resp_rd),
        .pend_rs1  (w_pend_rs1),
        .pend_rs2  (w_pend_rs2),
        .pend_rd   (w_pend_rd),
        .pend_exu  (w_pend_exu),
        .pend_resp (w_pend_resp)
    );

    // EXU may only write a register that has no load still in flight to it
    assign w_exu_wins     = (r_starve_cnt == STARVE_MAX);
    assign w_exu_eligible = exu_valid & ~w_pend_exu;

    assign exu_ready      = ~rst & w_exu_eligible & (w_exu_wins | ~ld_resp_valid);
    assign ld_resp_ready  = ~rst & ~(w_exu_wins & w_exu_eligible);
    assign ld_issue_ready = ~rst & (r_outstanding < CNT_MAX);

    assign w_exu_hs   = exu_valid & exu_ready;
    assign w_resp_hs  = ld_resp_valid & ld_resp_ready;
    assign w_issue_hs = ld_issue_valid & ld_issue_ready;
    assign w_arb_loss = w_exu_eligible & ~exu_ready;
    assign w_resp_bad = (ld_resp_rd != '0 && !w_pend_resp) || (r_outstanding == '0);

    assign dec_stall = (dec_rs1 != '0 && w_pend_rs1)
                     | (dec_rs2 != '0 && w_pend_rs2)
                     | (dec_rd  != '0 && w_pend_rd);

    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = exu_rd;
        rf_wdata = exu_data;
        if (w_resp_hs) begin
            rf_wen   = (ld_resp_rd != '0);
            rf_waddr = ld_resp_rd;
            rf_wdata = ld_resp_data;
        end else if (w_exu_hs) begin
            rf_wen   = (exu_rd != '0);
        end
    end

    always_comb begin
        w_outstanding_next = r_outstanding;
        unique case ({w_issue_hs, w_resp_hs})
            2'b10:   w_outstanding_next = r_outstanding + CNT_W'(1);
            2'b01:   if (r_outstanding != '0) w_outstanding_next = r_outstanding - CNT_W'(1);
            default: w_outstanding_next = r_outstanding;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_starve_cnt  <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (!exu_valid || w_exu_hs) begin
                r_starve_cnt <= '0;
            end else if (w_arb_loss && r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
            if (w_resp_hs && w_resp_bad) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign outstanding = r_outstanding;
    assign proto_err   = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25030085_wb_sched.sv
// ============================================================================
// Module   : tb_ysyx_25030085_wb_sched
// Brief    : Directed bench for the write-back scheduler with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25030085_wb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        ld_issue_valid, ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic        ld_resp_valid, ld_resp_ready;
    logic [4:0]  ld_resp_rd;
    logic [31:0] ld_resp_data;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_stall, rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  outstanding;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    ysyx_25030085_wb_sched #(
        .MAX_OUTSTANDING (4),
        .STARVE_LIMIT    (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .exu_valid      (exu_valid),
        .exu_ready      (exu_ready),
        .exu_rd         (exu_rd),
        .exu_data       (exu_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_ready (ld_issue_ready),
        .ld_issue_rd    (ld_issue_rd),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_ready  (ld_resp_ready),
        .ld_resp_rd     (ld_resp_rd),
        .ld_resp_data   (ld_resp_data),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_rd         (dec_rd),
        .dec_stall      (dec_stall),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .outstanding    (outstanding),
        .proto_err      (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Settle combinational outputs, then compare the write port with the scoreboard.
    task automatic step(input string tag);
        wr_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_wen"},   {31'd0, rf_wen}, 32'd1);
            chk({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, e.addr});
            chk({tag, "_wdata"}, rf_wdata, e.data);
        end else begin
            chk({tag, "_nowrite"}, {31'd0, rf_wen}, 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        ld_issue_valid = 1'b1;
        ld_issue_rd    = rd;
        step("issue");
        chk("issue_ready", {31'd0, ld_issue_ready}, 32'd1);
        tick();
        ld_issue_valid = 1'b0;
    endtask

    task automatic respond(input logic [4:0] rd, input logic [31:0] data, input bit writes);
        ld_resp_valid = 1'b1;
        ld_resp_rd    = rd;
        ld_resp_data  = data;
        if (writes) exp_q.push_back('{addr: rd, data: data});
        step("resp");
        chk("resp_ready", {31'd0, ld_resp_ready}, 32'd1);
        tick();
        ld_resp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        ld_issue_valid = 1'b0; ld_issue_rd = '0;
        ld_resp_valid = 1'b1; ld_resp_rd = 5'd2; ld_resp_data = 32'hDEAD;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
        exu_valid = 1'b1; exu_rd = 5'd1; ld_issue_valid = 1'b1; ld_issue_rd = 5'd1;

        // Reset: all readies and write enable held low, response dropped
        tick();
        step("rst");
        chk("rst_exu_ready", {31'd0, exu_ready}, 32'd0);
        chk("rst_issue_ready", {31'd0, ld_issue_ready}, 32'd0);
        chk("rst_resp_ready", {31'd0, ld_resp_ready}, 32'd0);
        tick();
        exu_valid = 1'b0; ld_issue_valid = 1'b0; ld_resp_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_outstanding", {29'd0, outstanding}, 32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
        chk("rst_dec_stall", {31'd0, dec_stall}, 32'd0);
        tick();

        // 1: ALU write-back
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234;
        exp_q.push_back('{addr: 5'd5, data: 32'h1234});
        step("alu");
        chk("alu_exu_ready", {31'd0, exu_ready}, 32'd1);
        tick();
        exu_valid = 1'b0;

        // 2: load RAW hazard
        issue(5'd7);
        dec_rs1 = 5'd7;
        step("raw");
        chk("raw_stall", {31'd0, dec_stall}, 32'd1);
        chk("raw_outstanding", {29'd0, outstanding}, 32'd1);
        respond(5'd7, 32'hCAFE, 1'b1);
        step("raw_after");
        chk("raw_stall_clear", {31'd0, dec_stall}, 32'd0);
        chk("raw_outstanding0", {29'd0, outstanding}, 32'd0);
        dec_rs1 = '0;
        tick();

        // 3: conflict, LD wins three times then EXU once
        issue(5'd10); issue(5'd11); issue(5'd12); issue(5'd13);
        exu_valid = 1'b1; exu_rd = 5'd20; exu_data = 32'hE0E0;
        for (int i = 0; i < 3; i++) begin
            ld_resp_valid = 1'b1;
            ld_resp_rd    = 5'(10 + i);
            ld_resp_data  = 32'hA000 + 32'(i);
            exp_q.push_back('{addr: 5'(10 + i), data: 32'hA000 + 32'(i)});
            step("conf_ld");
            chk("conf_ld_exu_ready", {31'd0, exu_ready}, 32'd0);
            chk("conf_ld_resp_ready", {31'd0, ld_resp_ready}, 32'd1);
            tick();
        end
        ld_resp_rd = 5'd13; ld_resp_data = 32'hA003;
        exp_q.push_back('{addr: 5'd20, data: 32'hE0E0});
        step("conf_exu");
        chk("conf_exu_ready", {31'd0, exu_ready}, 32'd1);
        chk("conf_exu_resp_ready", {31'd0, ld_resp_ready}, 32'd0);
        tick();
        exu_rd = 5'd21; exu_data = 32'hE1E1;
        exp_q.push_back('{addr: 5'd13, data: 32'hA003});
        step("conf_after");
        chk("conf_after_exu_ready", {31'd0, exu_ready}, 32'd0);
        tick();
        exu_valid = 1'b0; ld_resp_valid = 1'b0;
        step("conf_idle");
        chk("conf_outstanding0", {29'd0, outstanding}, 32'd0);
        tick();

        // 4: outstanding limit, no credit from a same-cycle response
        issue(5'd14); issue(5'd15); issue(5'd16); issue(5'd17);
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd18;
        step("full");
        chk("full_outstanding", {29'd0, outstanding}, 32'd4);
        chk("full_issue_ready", {31'd0, ld_issue_ready}, 32'd0);
        ld_resp_valid = 1'b1; ld_resp_rd = 5'd14; ld_resp_data = 32'h1414;
        exp_q.push_back('{addr: 5'd14, data: 32'h1414});
        step("full_resp");
        chk("full_resp_issue_ready", {31'd0, ld_issue_ready}, 32'd0);
        tick();
        ld_resp_valid = 1'b0; ld_issue_valid = 1'b0;
        step("full_after");
        chk("full_outstanding3", {29'd0, outstanding}, 32'd3);
        chk("full_issue_ready1", {31'd0, ld_issue_ready}, 32'd1);
        tick();
        respond(5'd15, 32'h1515, 1'b1);
        respond(5'd16, 32'h1616, 1'b1);
        respond(5'd17, 32'h1717, 1'b1);

        // 5: edge cases
        issue(5'd0);
        dec_rs1 = 5'd0;
        step("x0");
        chk("x0_stall", {31'd0, dec_stall}, 32'd0);
        chk("x0_outstanding", {29'd0, outstanding}, 32'd1);
        respond(5'd0, 32'h5555, 1'b0);
        step("x0_after");
        chk("x0_outstanding0", {29'd0, outstanding}, 32'd0);
        chk("x0_proto_err", {31'd0, proto_err}, 32'd0);

        issue(5'd9);
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h9999;
        step("waw");
        chk("waw_exu_ready", {31'd0, exu_ready}, 32'd0);
        tick();
        exu_valid = 1'b0;
        respond(5'd9, 32'h0909, 1'b1);
        step("waw_after");
        chk("waw_proto_err", {31'd0, proto_err}, 32'd0);

        issue(5'd4);
        respond(5'd3, 32'h3333, 1'b1);
        step("perr");
        chk("perr_proto_err", {31'd0, proto_err}, 32'd1);
        chk("perr_outstanding", {29'd0, outstanding}, 32'd0);

        // 6: reset with loads in flight
        issue(5'd22); issue(5'd23);
        dec_rs1 = 5'd4; dec_rs2 = 5'd22; dec_rd = 5'd23;
        step("mid");
        chk("mid_stall", {31'd0, dec_stall}, 32'd1);
        chk("mid_outstanding", {29'd0, outstanding}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        step("rst2");
        chk("rst2_outstanding", {29'd0, outstanding}, 32'd0);
        chk("rst2_proto_err", {31'd0, proto_err}, 32'd0);
        chk("rst2_dec_stall", {31'd0, dec_stall}, 32'd0);
        chk("rst2_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
